// File: rtl/alu_issue.sv
// ALU issue stage: decodes ALUOp/funct into a 4-bit ALU control code and buffers up to two ops.
// Latency 1 cycle from accept to presentation; in_ready depends only on the stored entry count.
module alu_issue #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       control,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             illegal
);

    typedef struct packed {
        logic [3:0]       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ill;
    } entry_t;

    entry_t     new_e;
    entry_t     e0_q, e0_d;
    entry_t     e1_q, e1_d;
    logic [1:0] count_q, count_d;
    logic       push;
    logic       pop;

    always_comb begin
        new_e.a   = in_a;
        new_e.b   = in_b;
        new_e.ill = 1'b0;
        new_e.ctl = 4'b0010;
        case (alu_op)
            2'b00: new_e.ctl = 4'b0010;
            2'b01: new_e.ctl = 4'b0110;
            2'b11: new_e.ctl = 4'b0001;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: new_e.ctl = 4'b0010;
                    6'b100010, 6'b100011: new_e.ctl = 4'b0110;
                    6'b100100:            new_e.ctl = 4'b0000;
                    6'b100101:            new_e.ctl = 4'b0001;
                    6'b100111:            new_e.ctl = 4'b1100;
                    6'b101010:            new_e.ctl = 4'b0111;
                    default: begin
                        new_e.ctl = 4'b0010;
                        new_e.ill = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign control   = e0_q.ctl;
    assign a         = e0_q.a;
    assign b         = e0_q.b;
    assign illegal   = e0_q.ill;

    // e0 is always the head; on a pop that empties the stage it keeps the last head values.
    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        push    = in_valid && in_ready && !flush;
        pop     = out_valid && out_ready;
        if (flush) begin
            count_d = 2'd0;
            e0_d    = '0;
            e1_d    = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = new_e;
                    else                 e1_d = new_e;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) e0_d = e1_q;
                    count_d = count_q - 2'd1;
                end
                // push and pop together only happen at count 1: the new op becomes the head
                2'b11:   e0_d = new_e;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule
